apu_mix_decimator: RTL and testbench
====================================

Name: apu_mix_decimator

Overview:
- Downstream of the APU audio channels. Consumes the per-channel digital levels SQA, SQB, TRI, RND and DMC that also drive the AUX_A/AUX_B DACs.
- Forms a weighted linear mix, boxcar-averages it over 2^DECIM_LOG2 channel-clock sample strobes, and buffers the 16-bit PCM samples in a small FIFO with a valid/ready output.
- Feeds a digital audio sink (I2S/HDMI bridge or capture logic) in place of the analog pins.

Parameters:
DECIM_LOG2, 5, log2 of sample_en pulses averaged per output sample (range 1..8)
FIFO_DEPTH, 4, output FIFO entries, power of two, at least 2

Ports:
CLK  input  1  master clock; all state on rising edge
n_RES  input  1  asynchronous active-low reset
sample_en  input  1  one-cycle strobe, one per APU channel-clock tick (ACLK rate)
SQA  input  4  square A level
SQB  input  4  square B level
TRI  input  4  triangle level
RND  input  4  noise level
DMC  input  7  DPCM level
pcm_data  output  16  two's-complement PCM sample at FIFO head
pcm_valid  output  1  FIFO non-empty
pcm_ready  input  1  sink accepts head when pcm_valid and pcm_ready are both high
ovr  output  1  sticky overrun flag
ovr_clr  input  1  clears ovr

Behaviour:
- Reset is asynchronous and active-low on n_RES. All of the following are zeroed: mix register, accumulator, pulse counter, FIFO pointers, ovr, DC-filter state. Outputs after reset: pcm_valid=0, pcm_data=0, ovr=0.
- Stage 1, mix, registered on the sample_en cycle:
  - mix = 25*(SQA+SQB) + 28*TRI + 16*RND + 11*DMC, unsigned 12 bits, maximum 2807, cannot overflow.
  - Inputs are sampled only when sample_en=1 and ignored otherwise.
- Stage 2, accumulate, in the cycle after the mix is registered:
  - acc (12+DECIM_LOG2 bits) += mix, and the pulse counter increments.
  - On the 2^DECIM_LOG2-th mix: avg = (acc + mix) >> DECIM_LOG2. In the same cycle acc is reloaded to 0 and the counter wraps to 0.
  - x = avg << 3, unsigned range 0..22456, always positive as signed 16.
- Push:
  - x (or the filtered y when APU_DCBLOCK_EN is defined) is written to the FIFO at the end of the avg cycle.
  - Latency: sample_en of the final pulse at cycle N gives pcm_valid visible at N+3 if the FIFO was empty. Add 1 cycle when APU_DCBLOCK_EN is defined.
  - The FIFO head is registered. There is no combinational bypass from push to pcm_data.
- Pop: occurs when pcm_valid and pcm_ready are both high. After a pop, pcm_data shows the next entry in the following cycle. When the FIFO is empty, pcm_data holds its last value.
- Boundaries:
  - Full with push and no pop in the same cycle: the new sample is dropped, ovr is set, and FIFO contents are unchanged.
  - Full with push and pop in the same cycle: both are accepted and ovr is unchanged.
  - Empty with push and pop: the pop is ignored because pcm_valid=0.
  - ovr_clr in the same cycle as a new overrun: set wins.
  - sample_en pulses on back-to-back cycles are legal. The pipeline accepts one mix per cycle with no stall.
  - FIFO backpressure never stalls accumulation. Samples are lost only through overrun.
- Reset mid-accumulation discards the partial sum. After release, the next output averages exactly 2^DECIM_LOG2 fresh pulses.

Optional Feature:
- Macro APU_DCBLOCK_EN enables a DC-blocking high-pass filter.
- Defined: adds a registered filter stage y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8).
  - Arithmetic is 18-bit signed internally; the result is saturated to the 16-bit signed range before push.
  - x[-1] = 0 and y[-1] = 0 after reset.
  - Adds one cycle of latency.
- Undefined: pcm_data = x zero-extended, so output is always in 0..22456.

Test Plan:
- All inputs 0, 32 sample_en pulses spaced 3 cycles apart -> one sample 0x0000; pcm_valid rises 3 cycles after the 32nd pulse.
- SQA=15, SQB=15, others 0, 32 pulses -> pcm_data = 6000 (0x1770). With APU_DCBLOCK_EN the first sample is also 6000, and later samples decay monotonically toward 0 (second sample 5977).
- All inputs at maximum (15, 15, 15, 15, 127), back-to-back pulses every cycle -> pcm_data = 22456 (0x57B8) every 32 cycles, with no sample lost while pcm_ready=1.
- pcm_ready=0, produce 5 samples with FIFO_DEPTH=4 -> 4 stored and ovr=1 after the 5th. Then ovr_clr=1 with pcm_ready=1 -> the 4 original samples drain in order and ovr=0.
- FIFO full, next push coinciding with a pop -> sample accepted, ovr stays 0, and the entry count stays 4.
- n_RES asserted after 10 of 32 pulses, then released -> pcm_valid=0 immediately. The next sample equals the average of the 32 post-reset pulses only, e.g. 750*8 = 6000 for the square-max stimulus.

Source files
------------

// File: rtl/apu_mix_decimator_if.sv
// PCM output stream of apu_mix_decimator: 16-bit sample with valid/ready handshake.
interface apu_mix_decimator_if;
  logic [15:0] pcm_data;
  logic        pcm_valid;
  logic        pcm_ready;

  modport master (output pcm_data, output pcm_valid, input pcm_ready);
  modport slave  (input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/apu_mix_decimator.sv
// APU channel mixer: weighted mix, boxcar decimation by 2^DECIM_LOG2, PCM FIFO with sticky overrun.
// Define APU_DCBLOCK_EN to insert a registered DC-blocking high-pass stage before the FIFO.
module apu_mix_decimator #(
  parameter int DECIM_LOG2 = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        n_RES,
  input  logic                        sample_en,
  input  logic [3:0]                  SQA,
  input  logic [3:0]                  SQB,
  input  logic [3:0]                  TRI,
  input  logic [3:0]                  RND,
  input  logic [6:0]                  DMC,
  apu_mix_decimator_if.master         pcm,
  output logic                        ovr,
  input  logic                        ovr_clr
);

  localparam int ACC_W = 12 + DECIM_LOG2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [11:0]           mix_p1_q, mix_p1_d;
  logic                  vld_p1_q, vld_p1_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [DECIM_LOG2-1:0] pcnt_q, pcnt_d;
  logic [ACC_W-1:0]      sum_p1;
  logic [11:0]           avg_p1;
  logic [15:0]           x_p1;
  logic                  last_p1;

  logic                  push;
  logic [15:0]           push_data;

  logic [15:0]           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  head_vld_q, head_vld_d;
  logic [15:0]           head_q, head_d;
  logic                  ovr_q, ovr_d;
  logic                  pop, full, push_ok, overrun, load, mem_nonempty;

`ifdef APU_DCBLOCK_EN
  logic [15:0]           x_p2_q, x_p2_d;
  logic                  vld_p2_q, vld_p2_d;
  logic [15:0]           xprev_q, xprev_d;
  logic signed [15:0]    yprev_q, yprev_d;
  logic signed [17:0]    x_p2_s, xprev_s, yprev_s, y_full_p2;
  logic signed [15:0]    y_sat_p2;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'sh7FFF;
    else if (v < -18'sd32768) return 16'sh8000;
    else                      return $signed(v[15:0]);
  endfunction
`endif

  always_comb begin
    // stage p1: mix registered on the strobe cycle
    mix_p1_d = mix_p1_q;
    vld_p1_d = sample_en;
    if (sample_en) begin
      mix_p1_d = 12'd25 * (12'(SQA) + 12'(SQB)) + 12'd28 * 12'(TRI)
               + 12'd16 * 12'(RND) + 12'd11 * 12'(DMC);
    end

    // stage p2: accumulate; the final pulse folds its mix into the average directly
    sum_p1  = acc_q + ACC_W'(mix_p1_q);
    avg_p1  = sum_p1[ACC_W-1:DECIM_LOG2];
    x_p1    = {1'b0, avg_p1, 3'b000};
    last_p1 = vld_p1_q && (pcnt_q == '1);
    acc_d   = acc_q;
    pcnt_d  = pcnt_q;
    if (vld_p1_q) begin
      pcnt_d = pcnt_q + 1'b1;
      acc_d  = last_p1 ? '0 : sum_p1;
    end

`ifdef APU_DCBLOCK_EN
    // stage p3: y[n] = x[n] - x[n-1] + y[n-1] - y[n-1]/256
    x_p2_d    = last_p1 ? x_p1 : x_p2_q;
    vld_p2_d  = last_p1;
    x_p2_s    = $signed({2'b00, x_p2_q});
    xprev_s   = $signed({2'b00, xprev_q});
    yprev_s   = $signed({{2{yprev_q[15]}}, yprev_q});
    y_full_p2 = x_p2_s - xprev_s + yprev_s - (yprev_s >>> 8);
    y_sat_p2  = sat16(y_full_p2);
    xprev_d   = vld_p2_q ? x_p2_q : xprev_q;
    yprev_d   = vld_p2_q ? y_sat_p2 : yprev_q;
    push      = vld_p2_q;
    push_data = $unsigned(y_sat_p2);
`else
    push      = last_p1;
    push_data = x_p1;
`endif

    // FIFO: head register counts as one of the FIFO_DEPTH entries
    pop          = head_vld_q && pcm.pcm_ready;
    full         = (cnt_q == CNT_W'(FIFO_DEPTH));
    push_ok      = push && (!full || pop);
    overrun      = push && full && !pop;
    mem_nonempty = (cnt_q != CNT_W'(head_vld_q));
    load         = (!head_vld_q || pop) && mem_nonempty;
    head_d       = load ? fifo_mem[rd_ptr_q] : head_q;
    head_vld_d   = load || (head_vld_q && !pop);
    rd_ptr_d     = rd_ptr_q + PTR_W'(load);
    wr_ptr_d     = wr_ptr_q + PTR_W'(push_ok);
    cnt_d        = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);

    ovr_d = ovr_clr ? 1'b0 : ovr_q;
    if (overrun) ovr_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      mix_p1_q   <= '0;
      vld_p1_q   <= 1'b0;
      acc_q      <= '0;
      pcnt_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
      ovr_q      <= 1'b0;
    end else begin
      mix_p1_q   <= mix_p1_d;
      vld_p1_q   <= vld_p1_d;
      acc_q      <= acc_d;
      pcnt_q     <= pcnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef APU_DCBLOCK_EN
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      x_p2_q   <= '0;
      vld_p2_q <= 1'b0;
      xprev_q  <= '0;
      yprev_q  <= '0;
    end else begin
      x_p2_q   <= x_p2_d;
      vld_p2_q <= vld_p2_d;
      xprev_q  <= xprev_d;
      yprev_q  <= yprev_d;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= push_data;
  end

  assign pcm.pcm_data  = head_q;
  assign pcm.pcm_valid = head_vld_q;
  assign ovr           = ovr_q;

endmodule

// File: tb/tb_apu_mix_decimator.sv
// Self-checking bench for apu_mix_decimator: vector table, corner sequences, randomized scoreboard.
module tb_apu_mix_decimator;

`ifdef APU_DCBLOCK_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic       CLK = 1'b0;
  logic       n_RES = 1'b0;
  logic       sample_en = 1'b0;
  logic [3:0] SQA = '0, SQB = '0, TRI = '0, RND = '0;
  logic [6:0] DMC = '0;
  logic       ovr;
  logic       ovr_clr = 1'b0;

  apu_mix_decimator_if pcm ();

  apu_mix_decimator #(.DECIM_LOG2(5), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .n_RES(n_RES), .sample_en(sample_en),
    .SQA(SQA), .SQB(SQB), .TRI(TRI), .RND(RND), .DMC(DMC),
    .pcm(pcm), .ovr(ovr), .ovr_clr(ovr_clr)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;
  int dc_x = 0, dc_y = 0;
  int exp_q[$];
  bit mon_en = 1'b0;
  int mon_cnt = 0;

  typedef struct {
    string name;
    int sqa, sqb, trg, rnd, dmc, gap, exp_x;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int mixf(input int a, input int b, input int t, input int r, input int d);
    return 25 * (a + b) + 28 * t + 16 * r + 11 * d;
  endfunction

  // Expected output word for a boxcar result x, including the optional high-pass.
  function automatic int dc_model(input int x);
`ifdef APU_DCBLOCK_EN
    int y;
    y = x - dc_x + dc_y - (dc_y >>> 8);
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    dc_x = x;
    dc_y = y;
    return y & 32'hFFFF;
`else
    return x;
`endif
  endfunction

  function automatic int avg_x(input int sum);
    return (sum / 32) * 8;
  endfunction

  // n strobes; gap idle cycles between strobes. Returns one tick after the last strobe.
  task automatic pulses(input int n, input bit rnd_in, input int gapmax, output int sum);
    sum = 0;
    for (int i = 0; i < n; i++) begin
      if (i != 0) repeat (rnd_in ? $urandom_range(0, gapmax) : gapmax) tick();
      if (rnd_in) begin
        SQA = 4'($urandom_range(0, 15));
        SQB = 4'($urandom_range(0, 15));
        TRI = 4'($urandom_range(0, 15));
        RND = 4'($urandom_range(0, 15));
        DMC = 7'($urandom_range(0, 127));
      end
      sample_en = 1'b1;
      sum += mixf(SQA, SQB, TRI, RND, DMC);
      tick();
      sample_en = 1'b0;
    end
  endtask

  task automatic set_in(input int a, input int b, input int t, input int r, input int d);
    SQA = 4'(a); SQB = 4'(b); TRI = 4'(t); RND = 4'(r); DMC = 7'(d);
  endtask

  task automatic drain4(input string tag);
    pcm.pcm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_valid"}, pcm.pcm_valid, 1);
      check({tag, "_data"}, pcm.pcm_data, exp_q.pop_front());
      tick();
      ovr_clr = 1'b0;
    end
    check({tag, "_empty"}, pcm.pcm_valid, 0);
    check({tag, "_ovr"}, ovr, 0);
    pcm.pcm_ready = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (mon_en && pcm.pcm_valid && pcm.pcm_ready) begin
      mon_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL mon_unexpected: got %0d, expected no sample", pcm.pcm_data);
      end else begin
        check("mon_data", pcm.pcm_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum, y, c0;
    tbl[0] = '{"zeros",   0,  0,  0,  0,   0, 2,     0};
    tbl[1] = '{"squares", 15, 15, 0,  0,   0, 1,  6000};
    tbl[2] = '{"allmax",  15, 15, 15, 15, 127, 0, 22456};
    tbl[3] = '{"tri",     0,  0,  15, 0,   0, 0,  3360};
    tbl[4] = '{"dmc",     0,  0,  0,  0, 127, 1, 11176};
    tbl[5] = '{"noise",   0,  0,  0,  15,  0, 2,  1920};
    tbl[6] = '{"mixed",   3,  7,  9,  2,  50, 0,  8672};

    pcm.pcm_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", pcm.pcm_valid, 0);
    check("rst_data", pcm.pcm_data, 0);
    check("rst_ovr", ovr, 0);
    n_RES = 1'b1;
    tick();

    // table: one sample per entry, exact latency and hold-after-pop
    for (int v = 0; v < 7; v++) begin
      set_in(tbl[v].sqa, tbl[v].sqb, tbl[v].trg, tbl[v].rnd, tbl[v].dmc);
      pulses(32, 1'b0, tbl[v].gap, sum);
      y = dc_model(tbl[v].exp_x);
      repeat (LAT - 2) tick();
      check({tbl[v].name, "_early"}, pcm.pcm_valid, 0);
      tick();
      check({tbl[v].name, "_valid"}, pcm.pcm_valid, 1);
      check({tbl[v].name, "_data"}, pcm.pcm_data, y);
      pcm.pcm_ready = 1'b1;
      tick();
      pcm.pcm_ready = 1'b0;
      check({tbl[v].name, "_popped"}, pcm.pcm_valid, 0);
      check({tbl[v].name, "_hold"}, pcm.pcm_data, y);
    end

    // overrun: five samples into a four-entry FIFO
    for (int k = 1; k <= 5; k++) begin
      set_in(3 * k, 0, 0, 0, 0);
      pulses(32, 1'b0, 0, sum);
      y = dc_model(avg_x(sum));
      if (k <= 4) exp_q.push_back(y);
    end
    repeat (5) tick();
    check("ovr_set", ovr, 1);
    ovr_clr = 1'b1;
    drain4("ovr_drain");

    // full FIFO: push coincides with pop
    for (int k = 1; k <= 4; k++) begin
      set_in(2 * k, 0, 0, 0, 0);
      pulses(32, 1'b0, 0, sum);
      exp_q.push_back(dc_model(avg_x(sum)));
    end
    repeat (5) tick();
    check("full_noovr", ovr, 0);
    set_in(10, 0, 0, 0, 0);
    pulses(32, 1'b0, 0, sum);
    repeat (LAT - 3) tick();
    check("simul_head", pcm.pcm_data, exp_q.pop_front());
    pcm.pcm_ready = 1'b1;
    tick();
    pcm.pcm_ready = 1'b0;
    exp_q.push_back(dc_model(avg_x(sum)));
    repeat (3) tick();
    check("simul_ovr", ovr, 0);
    drain4("simul_drain");

    // reset mid-accumulation with a sample waiting in the FIFO
    set_in(15, 15, 0, 0, 0);
    pulses(32, 1'b0, 0, sum);
    y = dc_model(avg_x(sum));
    repeat (5) tick();
    check("pre_rst_valid", pcm.pcm_valid, 1);
    set_in(15, 15, 15, 15, 127);
    pulses(10, 1'b0, 0, sum);
    n_RES = 1'b0;
    #1;
    check("rst_mid_valid", pcm.pcm_valid, 0);
    check("rst_mid_data", pcm.pcm_data, 0);
    repeat (2) tick();
    n_RES = 1'b1;
    dc_x = 0;
    dc_y = 0;
    set_in(15, 15, 0, 0, 0);
    pulses(32, 1'b0, 1, sum);
    repeat (LAT - 1) tick();
    check("post_rst_valid", pcm.pcm_valid, 1);
    check("post_rst_data", pcm.pcm_data, dc_model(6000));
    pcm.pcm_ready = 1'b1;
    tick();

    // back-to-back strobes at full scale, sink always ready
    mon_en = 1'b1;
    c0 = mon_cnt;
    set_in(15, 15, 15, 15, 127);
    for (int s = 0; s < 3; s++) begin
      pulses(32, 1'b0, 0, sum);
      exp_q.push_back(dc_model(avg_x(sum)));
    end
    repeat (8) tick();
    check("b2b_count", mon_cnt - c0, 3);

    // randomized inputs and gaps against the scoreboard
    c0 = mon_cnt;
    for (int s = 0; s < 8; s++) begin
      pulses(32, 1'b1, 2, sum);
      exp_q.push_back(dc_model(avg_x(sum)));
    end
    repeat (8) tick();
    check("rand_count", mon_cnt - c0, 8);
    check("rand_left", exp_q.size(), 0);
    check("rand_ovr", ovr, 0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
